// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - ALU op type and the issue-stage handshake interface
// slave = the issue stage, master = upstream/downstream driver side
package riscv_pkg;
   typedef enum logic [1:0] {
      ALU_ADD = 2'd0,
      ALU_SUB = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_op_t;
endpackage

interface alu_issue_stage_if #(
   parameter int XLEN = 32
);
   logic                flush_i;
   logic                in_valid_i;
   logic                in_ready_o;
   logic [31:0]         instr_i;
   logic [XLEN-1:0]     rs1_data_i;
   logic [XLEN-1:0]     rs2_data_i;
   logic                out_valid_o;
   logic                out_ready_i;
   riscv_pkg::alu_op_t  op_o;
   logic [XLEN-1:0]     A_o;
   logic [XLEN-1:0]     B_o;
   logic [4:0]          rd_o;
   logic                illegal_o;

   modport slave (
      input  flush_i, in_valid_i, instr_i, rs1_data_i, rs2_data_i, out_ready_i,
      output in_ready_o, out_valid_o, op_o, A_o, B_o, rd_o, illegal_o
   );

   modport master (
      output flush_i, in_valid_i, instr_i, rs1_data_i, rs2_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, op_o, A_o, B_o, rd_o, illegal_o
   );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode/issue register stage feeding the ALU
// Optional one-entry skid buffer (flop-driven in_ready_o) under ALU_ISSUE_SKID_EN.
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input logic              clk_i,
   input logic              rst_ni,
   alu_issue_stage_if.slave bus
);
   import riscv_pkg::*;

   typedef struct packed {
      alu_op_t         op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [4:0]      rd;
      logic            ill;
   } entry_t;

   localparam entry_t RESET_ENTRY = '{op: ALU_ADD, a: '0, b: '0, rd: '0, ill: 1'b0};

   entry_t dec;
   entry_t out_q, out_d;
   logic   out_valid_q, out_valid_d;
   logic   in_ready;
   logic   fire_in;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal;
   logic       is_imm;
   alu_op_t    dec_op;
   logic       unused_rs_idx;

   assign opcode        = bus.instr_i[6:0];
   assign funct3        = bus.instr_i[14:12];
   assign funct7        = bus.instr_i[31:25];
   assign unused_rs_idx = ^bus.instr_i[19:15];

   always_comb begin
      legal  = 1'b0;
      is_imm = 1'b0;
      dec_op = ALU_ADD;
      if (opcode == 7'b0110011) begin
         if (funct7 == 7'b0000000) begin
            case (funct3)
               3'b000:  begin legal = 1'b1; dec_op = ALU_ADD; end
               3'b111:  begin legal = 1'b1; dec_op = ALU_AND; end
               3'b110:  begin legal = 1'b1; dec_op = ALU_OR;  end
               default: legal = 1'b0;
            endcase
         end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            legal  = 1'b1;
            dec_op = ALU_SUB;
         end
      end else if (opcode == 7'b0010011) begin
         is_imm = 1'b1;
         case (funct3)
            3'b000:  begin legal = 1'b1; dec_op = ALU_ADD; end
            3'b111:  begin legal = 1'b1; dec_op = ALU_AND; end
            3'b110:  begin legal = 1'b1; dec_op = ALU_OR;  end
            default: legal = 1'b0;
         endcase
      end

      // Illegal instructions still issue, but with a zeroed payload.
      dec     = RESET_ENTRY;
      dec.ill = 1'b1;
      if (legal) begin
         dec.op  = dec_op;
         dec.a   = bus.rs1_data_i;
         dec.b   = is_imm ? {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:20]}
                          : bus.rs2_data_i;
         dec.rd  = bus.instr_i[11:7];
         dec.ill = 1'b0;
      end
   end

   assign fire_in = bus.in_valid_i && in_ready;

`ifdef ALU_ISSUE_SKID_EN
   entry_t skid_q, skid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   ready_q;

   assign in_ready = ready_q;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (bus.flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || bus.out_ready_i) begin
         // A full skid blocks input, so fire_in cannot coincide with draining it.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = fire_in;
            if (fire_in) out_d = dec;
         end
      end else if (fire_in) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_q       <= RESET_ENTRY;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= !skid_valid_d;
      end
   end
`else
   assign in_ready = !out_valid_q || bus.out_ready_i;

   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (bus.flush_i) begin
         out_valid_d = 1'b0;
      end else if (fire_in) begin
         out_d       = dec;
         out_valid_d = 1'b1;
      end else if (bus.out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q       <= RESET_ENTRY;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid_q;
   assign bus.op_o        = out_q.op;
   assign bus.A_o         = out_q.a;
   assign bus.B_o         = out_q.b;
   assign bus.rd_o        = out_q.rd;
   assign bus.illegal_o   = out_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
// Random and directed traffic checked against a queue-based reference model.
module tb_alu_issue_stage;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   alu_issue_stage_if #(.XLEN(32)) bus ();

   alu_issue_stage #(.XLEN(32)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      alu_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   accepts = 0;

`ifdef ALU_ISSUE_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference decode: straight from the RV32I field rules.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs1,
                                  input logic [31:0] rs2);
      exp_t    e;
      bit      legal = 0;
      bit      imm_form = 0;
      alu_op_t op = ALU_ADD;
      int      imm = int'($signed(ins[31:20]));
      int      f3 = int'(ins[14:12]);
      int      f7 = int'(ins[31:25]);
      e = '{op: ALU_ADD, a: 0, b: 0, rd: 0, ill: 1'b1};
      if (ins[6:0] == 7'h33) begin
         if (f7 == 0 && f3 == 0)         begin legal = 1; op = ALU_ADD; end
         else if (f7 == 32 && f3 == 0)   begin legal = 1; op = ALU_SUB; end
         else if (f7 == 0 && f3 == 7)    begin legal = 1; op = ALU_AND; end
         else if (f7 == 0 && f3 == 6)    begin legal = 1; op = ALU_OR;  end
      end else if (ins[6:0] == 7'h13) begin
         imm_form = 1;
         if (f3 == 0)      begin legal = 1; op = ALU_ADD; end
         else if (f3 == 7) begin legal = 1; op = ALU_AND; end
         else if (f3 == 6) begin legal = 1; op = ALU_OR;  end
      end
      if (legal)
         e = '{op: op, a: rs1, b: (imm_form ? imm : rs2), rd: ins[11:7], ill: 1'b0};
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      int          sel = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
         0: begin
            r[6:0] = 7'h33;
            if (sel == 0) r[31:25] = 7'h00;
            else if (sel == 1) r[31:25] = 7'h20;
         end
         1: r[6:0] = 7'h13;
         2: ;
         default: begin r[6:0] = 7'h33; r[31:25] = 7'h00; end
      endcase
      return r;
   endfunction

   // Output side compares against the queue head; input side pushes accepted beats.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         logic exp_valid;
         logic exp_ready;
         exp_valid = (sb.size() > 0);
`ifdef ALU_ISSUE_SKID_EN
         exp_ready = (sb.size() < 2);
`else
         exp_ready = (sb.size() == 0) || bus.out_ready_i;
`endif
         check("out_valid", 32'(bus.out_valid_o), 32'(exp_valid));
         check("in_ready", 32'(bus.in_ready_o), 32'(exp_ready));
         if (exp_valid && bus.out_valid_o) begin
            check("op", 32'(bus.op_o), 32'(sb[0].op));
            check("A", bus.A_o, sb[0].a);
            check("B", bus.B_o, sb[0].b);
            check("rd", 32'(bus.rd_o), 32'(sb[0].rd));
            check("illegal", 32'(bus.illegal_o), 32'(sb[0].ill));
         end
         if (bus.flush_i) begin
            sb.delete();
         end else begin
            if (exp_valid && bus.out_ready_i) void'(sb.pop_front());
            if (bus.in_valid_i && exp_ready) begin
               sb.push_back(model(bus.instr_i, bus.rs1_data_i, bus.rs2_data_i));
               accepts++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2);
      bus.in_valid_i = v;
      bus.instr_i    = ins;
      bus.rs1_data_i = r1;
      bus.rs2_data_i = r2;
   endtask

   initial begin
      int a0;
      bus.flush_i     = 1'b0;
      bus.out_ready_i = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0);

      #1 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("rst_op", 32'(bus.op_o), 32'(ALU_ADD));
      check("rst_A", bus.A_o, 32'd0);
      check("rst_B", bus.B_o, 32'd0);
      check("rst_rd", 32'(bus.rd_o), 32'd0);
      check("rst_illegal", 32'(bus.illegal_o), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Directed decode cases: add, sub, addi -1, ecall.
      drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
      tick();
      drive(1'b1, 32'h402081B3, 32'd3, 32'd10);
      tick();
      drive(1'b1, 32'hFFF08193, 32'd9, 32'd4);
      tick();
      drive(1'b1, 32'h00000073, 32'h1234, 32'h5678);
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      tick();
      tick();

      // Backpressure: four stalled cycles with input always offered.
      bus.out_ready_i = 1'b0;
      a0 = accepts;
      repeat (4) begin
         drive(1'b1, rand_instr(), $urandom, $urandom);
         tick();
      end
      check("bp_accepts", 32'(accepts - a0), 32'(DEPTH));
      check("bp_in_ready_low", 32'(bus.in_ready_o), 32'd0);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      bus.out_ready_i = 1'b1;
      repeat (3) tick();

      // Flush with entries held and a simultaneous input offer.
      bus.out_ready_i = 1'b0;
      repeat (3) begin
         drive(1'b1, rand_instr(), $urandom, $urandom);
         tick();
      end
      bus.flush_i = 1'b1;
      drive(1'b1, 32'h002081B3, 32'd1, 32'd2);
      tick();
      bus.flush_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      check("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("flush_in_ready", 32'(bus.in_ready_o), 32'd1);
      bus.out_ready_i = 1'b1;
      repeat (3) tick();

      // Asynchronous reset while stalled.
      bus.out_ready_i = 1'b0;
      repeat (2) begin
         drive(1'b1, rand_instr(), $urandom, $urandom);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      check("stall_out_valid", 32'(bus.out_valid_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("async_rst_A", bus.A_o, 32'd0);
      tick();
      rst_n = 1'b1;
      bus.out_ready_i = 1'b1;
      tick();

      // Randomised traffic with random backpressure and occasional flush.
      repeat (400) begin
         drive(1'($urandom_range(0, 1)), rand_instr(), $urandom, $urandom);
         bus.out_ready_i = ($urandom_range(0, 9) < 7);
         bus.flush_i     = ($urandom_range(0, 29) == 0);
         tick();
      end
      bus.flush_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      bus.out_ready_i = 1'b1;
      repeat (4) tick();
      check("drained_out_valid", 32'(bus.out_valid_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue register stage that drives the operand and opcode side of the ALU.
- Accepts an RV32I instruction word plus register-file read data under a valid/ready handshake.
- Decodes the instruction to a riscv_pkg::alu_op_t and the two ALU operands, then presents them registered to the ALU.
- Sits between the register-file read and the execute stage; single clock domain.

Parameters:
XLEN, 32, datapath width of operands (32 only for RV32I; other values unsupported)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  reset, asynchronous assert, active-low
flush_i  input  1  synchronous flush; drops all held entries
in_valid_i  input  1  upstream instruction valid
in_ready_o  output  1  stage can accept an instruction this cycle
instr_i  input  32  instruction word
rs1_data_i  input  XLEN  register-file value of rs1
rs2_data_i  input  XLEN  register-file value of rs2
out_valid_o  output  1  issued operation valid toward ALU
out_ready_i  input  1  execute stage accepts operation
op_o  output  alu_op_t  ALU operation (AND, OR, ADD, SUB)
A_o  output  XLEN  ALU operand A
B_o  output  XLEN  ALU operand B
rd_o  output  5  destination register index, instr[11:7]
illegal_o  output  1  instruction not decodable to an ALU op

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous, active-low; assertion takes effect immediately, deassertion is synchronous to clk_i.
- Reset values: out_valid_o=0, op_o=ADD, A_o=0, B_o=0, rd_o=0, illegal_o=0. in_ready_o=1 once out of reset.
- Handshake: transfer when valid&&ready on the same edge. Once raised, out_valid_o and all payload outputs hold stable until out_ready_i is sampled high.
- Latency: 1 cycle, input transfer to out_valid_o.
- Decode, R-type (opcode 0110011):
  - funct3=000, funct7=0000000 -> ADD
  - funct3=000, funct7=0100000 -> SUB
  - funct3=111, funct7=0 -> AND
  - funct3=110, funct7=0 -> OR
  - A=rs1_data_i, B=rs2_data_i.
- Decode, I-type (opcode 0010011):
  - funct3=000 -> ADD, 111 -> AND, 110 -> OR.
  - A=rs1_data_i, B=sign-extend(instr[31:20]) to XLEN.
- Any other opcode/funct combination:
  - illegal_o=1, op_o=ADD, A_o=0, B_o=0, rd_o=0.
  - Still issued as a normal handshake beat, never dropped.
- Decode is combinational on the input side; only the result is registered.
- Simultaneous accept and issue in the same cycle (in and out both firing): the new entry replaces the outgoing one with no bubble.
- flush_i:
  - Next edge clears out_valid_o and all buffered entries; payload registers are don't-care.
  - An input handshake in the flush cycle is discarded.
  - Flush has priority over every other event.
- Reset mid-transfer: held entries are lost; no partial beat is ever presented.

Optional Feature:
Macro ALU_ISSUE_SKID_EN.
- Undefined (default): single output register. in_ready_o = !out_valid_o || out_ready_i, a combinational path from out_ready_i. Full throughput.
- Defined: adds a one-entry skid register. in_ready_o is driven directly from a flop (high iff skid empty), with no combinational path from out_ready_i.
  - Input accepted while output stalled is captured in skid.
  - When the output fires, skid moves to output.
  - Ordering is preserved.
  - Reset and flush clear skid.
  - Latency is unchanged when the skid is empty.

Test Plan:
- ADD issue: rst_ni low then high; instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready_i=1 -> next cycle out_valid_o=1, op=ADD, A=5, B=7, rd=3, illegal=0.
- SUB and ADDI sign extension:
  - instr=0x402081B3, rs1=3, rs2=10 -> op=SUB, A=3, B=10.
  - instr=0xFFF08193 (addi x3,x1,-1) -> op=ADD, B=0xFFFFFFFF.
- Backpressure: out_ready_i=0 for 4 cycles with in_valid_i=1 -> outputs stable, no entry lost or duplicated. Without the macro, in_ready_o=0 after first accept. With the macro, exactly two entries accepted, then released in order.
- Illegal: instr=0x00000073 (ecall) -> out_valid_o=1, illegal_o=1, op=ADD, A=B=0, rd=0.
- Flush: two entries held (with macro), flush_i=1 together with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, the new instruction is not issued.
- Async reset mid-stall: drop rst_ni between clock edges -> out_valid_o=0 immediately, without waiting for a clock edge.
